acc_axil_cfg_slave: RTL and testbench

- AXI4-Lite responder for the Accelerator window of the SoC crossbar (base 0x5000_0000, length 0x1000).
- Holds the accelerator control, status and configuration registers.
- Drives start, configuration and interrupt signals to the accelerator core.
- Takes busy/done back from the core and exposes them to software.

---
 rtl/acc_axil_cfg_slave.sv | 99 +++++++++
 tb/tb_acc_axil_cfg_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_axil_cfg_slave.sv
// acc_axil_cfg_slave: AXI4-Lite control/status/config register slave for the accelerator window
module acc_axil_cfg_slave #(
  parameter logic [63:0] BaseAddr  = 64'h5000_0000,
  parameter logic [63:0] WindowLen = 64'h1000,
  parameter int          NumCfg    = 14
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [63:0]          awaddr_i,
  input  logic                 awvalid_i,
  output logic                 awready_o,
  input  logic [63:0]          wdata_i,
  input  logic [7:0]           wstrb_i,
  input  logic                 wvalid_i,
  output logic                 wready_o,
  output logic [1:0]           bresp_o,
  output logic                 bvalid_o,
  input  logic                 bready_i,
  input  logic [63:0]          araddr_i,
  input  logic                 arvalid_i,
  output logic                 arready_o,
  output logic [63:0]          rdata_o,
  output logic [1:0]           rresp_o,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic                 acc_start_o,
  input  logic                 acc_busy_i,
  input  logic                 acc_done_i,
  output logic [NumCfg*64-1:0] cfg_o,
  output logic                 irq_o
);
  typedef enum logic [1:0] {IDLE, WR_RESP, RD_RESP} state_t;
  state_t state, state_nx;
  logic [63:0] cfg [NumCfg];
  logic [63:0] w_word, r_word, rd_val;
  logic irq_en, done, w_hit, r_hit, w_acc, r_acc, done_clr, start;
  // word index within the window; low three address bits never matter
  assign w_word = (awaddr_i - BaseAddr) >> 3;
  assign r_word = (araddr_i - BaseAddr) >> 3;
  assign w_hit = awaddr_i >= BaseAddr && (awaddr_i - BaseAddr) < WindowLen;
  assign r_hit = araddr_i >= BaseAddr && (araddr_i - BaseAddr) < WindowLen;
  assign w_acc = rst_ni && state == IDLE && awvalid_i && wvalid_i;
  assign r_acc = rst_ni && state == IDLE && arvalid_i && !(awvalid_i && wvalid_i);
  assign awready_o = w_acc;
  assign wready_o  = w_acc;
  assign arready_o = r_acc;
  assign bvalid_o  = state == WR_RESP;
  assign rvalid_o  = state == RD_RESP;
  assign done_clr = w_acc && w_hit && w_word == 64'd1 && wstrb_i[0] && wdata_i[1];
  assign start    = w_acc && w_hit && w_word == 64'd0 && wstrb_i[0] && wdata_i[0];
  for (genvar g = 0; g < NumCfg; g++) begin : g_cfg
    assign cfg_o[g*64 +: 64] = cfg[g];
  end
  always_comb begin
    rd_val = '0;
    if (r_hit) begin
      if (r_word == 64'd0) rd_val[1] = irq_en;
      if (r_word == 64'd1) rd_val[1:0] = {done, acc_busy_i};
      for (int k = 0; k < NumCfg; k++)
        if (r_word == 64'(k + 2)) rd_val = cfg[k];
    end
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = w_acc ? WR_RESP : r_acc ? RD_RESP : IDLE;
    if (state == WR_RESP) state_nx = bready_i ? IDLE : WR_RESP;
    if (state == RD_RESP) state_nx = rready_i ? IDLE : RD_RESP;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bresp_o     <= '0;
      rresp_o     <= '0;
      rdata_o     <= '0;
      irq_en      <= 1'b0;
      done        <= 1'b0;
      irq_o       <= 1'b0;
      acc_start_o <= 1'b0;
      for (int k = 0; k < NumCfg; k++) cfg[k] <= '0;
    end else begin
      acc_start_o <= start;
      done        <= acc_done_i | (done & ~done_clr);
      irq_o       <= done & irq_en;
      if (w_acc) bresp_o <= w_hit ? 2'b00 : 2'b11;
      if (r_acc) begin
        rresp_o <= r_hit ? 2'b00 : 2'b11;
        rdata_o <= rd_val;
      end
      if (w_acc && w_hit && w_word == 64'd0 && wstrb_i[0]) irq_en <= wdata_i[1];
      for (int k = 0; k < NumCfg; k++)
        for (int b = 0; b < 8; b++)
          if (w_acc && w_hit && w_word == 64'(k + 2) && wstrb_i[b])
            cfg[k][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_acc_axil_cfg_slave.sv
// tb_acc_axil_cfg_slave: directed bench with a byte-level register model checked every cycle
module tb_acc_axil_cfg_slave;
  localparam int NCFG = 14;
  localparam logic [63:0] BASE = 64'h5000_0000;
  logic clk = 0, rst_ni = 0;
  logic [63:0] awaddr = 0, wdata = 0, araddr = 0;
  logic [7:0] wstrb = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, acc_busy = 0, acc_done = 0;
  logic awready, wready, bvalid, arready, rvalid, acc_start, irq;
  logic [1:0] bresp, rresp;
  logic [63:0] rdata;
  logic [NCFG*64-1:0] cfg_o;
  always #5 clk = ~clk;
  acc_axil_cfg_slave #(.BaseAddr(BASE), .WindowLen(64'h1000), .NumCfg(NCFG)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .acc_start_o(acc_start), .acc_busy_i(acc_busy), .acc_done_i(acc_done),
    .cfg_o(cfg_o), .irq_o(irq)
  );
  int errors = 0, checks = 0, start_cnt = 0;
  bit chk_on = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: config space as a flat byte array, one pending-response slot
  logic [7:0] m_cfg [NCFG*8];
  logic m_irq_en = 0, m_done = 0, m_irq = 0, m_start = 0;
  int m_pend = 0;
  logic [1:0] m_bresp = 0, m_rresp = 0;
  logic [63:0] m_rdata = 0;
  function automatic bit in_win(input logic [63:0] a);
    return a >= BASE && a < BASE + 64'h1000;
  endfunction
  function automatic logic [63:0] model_read(input logic [63:0] a);
    logic [63:0] off = (a - BASE) & ~64'h7;
    logic [63:0] v = 0;
    if (!in_win(a)) return 0;
    if (off == 0) return {62'b0, m_irq_en, 1'b0};
    if (off == 8) return {62'b0, m_done, acc_busy};
    if (off >= 16 && off < 64'(16 + 8 * NCFG))
      for (int b = 0; b < 8; b++) v[8*b +: 8] = m_cfg[int'(off) - 16 + b];
    return v;
  endfunction
  function automatic int cfg_bad();
    int n = 0;
    for (int i = 0; i < NCFG * 8; i++) if (cfg_o[8*i +: 8] !== m_cfg[i]) n++;
    return n;
  endfunction
  logic e_aw, e_ar, w_in, clr;
  logic [63:0] w_off;
  assign e_aw  = rst_ni && m_pend == 0 && awvalid && wvalid;
  assign e_ar  = rst_ni && m_pend == 0 && arvalid && !(awvalid && wvalid);
  assign w_in  = in_win(awaddr);
  assign w_off = (awaddr - BASE) & ~64'h7;
  assign clr   = e_aw && w_in && w_off == 8 && wstrb[0] && wdata[1];
  always @(posedge clk) begin
    if (!rst_ni) begin
      m_pend <= 0; m_bresp <= 0; m_rresp <= 0; m_rdata <= 0;
      m_irq_en <= 0; m_done <= 0; m_irq <= 0; m_start <= 0;
      for (int i = 0; i < NCFG * 8; i++) m_cfg[i] <= 0;
    end else begin
      m_start <= e_aw && w_in && w_off == 0 && wstrb[0] && wdata[0];
      m_irq   <= m_done && m_irq_en;
      m_done  <= acc_done || (m_done && !clr);
      if (e_aw) begin
        m_bresp <= w_in ? 2'd0 : 2'd3;
        m_pend  <= 1;
      end else if (e_ar) begin
        m_rresp <= in_win(araddr) ? 2'd0 : 2'd3;
        m_rdata <= model_read(araddr);
        m_pend  <= 2;
      end else if ((m_pend == 1 && bready) || (m_pend == 2 && rready)) m_pend <= 0;
      if (e_aw && w_in && w_off == 0 && wstrb[0]) m_irq_en <= wdata[1];
      if (e_aw && w_in && w_off >= 16 && w_off < 64'(16 + 8 * NCFG))
        for (int b = 0; b < 8; b++)
          if (wstrb[b]) m_cfg[int'(w_off) - 16 + b] <= wdata[8*b +: 8];
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("awready", awready, e_aw);
    chk("wready", wready, e_aw);
    chk("arready", arready, e_ar);
    chk("bvalid", bvalid, m_pend == 1);
    chk("rvalid", rvalid, m_pend == 2);
    chk("bresp", bresp, m_bresp);
    chk("rresp", rresp, m_rresp);
    chk("rdata", rdata, m_rdata);
    chk("acc_start", acc_start, m_start);
    chk("irq", irq, m_irq);
    chk("cfg_o bad bytes", 64'(cfg_bad()), 0);
  end
  always @(negedge clk) if (acc_start) start_cnt <= start_cnt + 1;
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                       input bit dpulse, output logic [1:0] resp);
    int k = 0;
    step();
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; acc_done = dpulse;
    @(negedge clk);
    while (!awready && k < 20) begin @(negedge clk); k++; end
    chk("write accept wait", 64'(k), 0);
    step();
    awvalid = 0; wvalid = 0; acc_done = 0; bready = 1;
    k = 0;
    @(negedge clk);
    while (!bvalid && k < 20) begin @(negedge clk); k++; end
    chk("bvalid latency", 64'(k), 0);
    resp = bresp;
    step();
    bready = 0;
  endtask
  task automatic read(input logic [63:0] a, output logic [63:0] d, output logic [1:0] resp);
    int k = 0;
    step();
    araddr = a; arvalid = 1;
    @(negedge clk);
    while (!arready && k < 20) begin @(negedge clk); k++; end
    chk("read accept wait", 64'(k), 0);
    step();
    arvalid = 0; rready = 1;
    k = 0;
    @(negedge clk);
    while (!rvalid && k < 20) begin @(negedge clk); k++; end
    chk("rvalid latency", 64'(k), 0);
    d = rdata; resp = rresp;
    step();
    rready = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [1:0] r;
    logic [63:0] d;
    int s0;
    awvalid = 1; wvalid = 1; awaddr = BASE + 'h10; wdata = '1; wstrb = '1;
    arvalid = 1; araddr = BASE;
    step();
    chk_on = 1;
    @(negedge clk);
    chk("reset awready", awready, 0);
    chk("reset arready", arready, 0);
    chk("reset bvalid", bvalid, 0);
    chk("reset cfg_o", 64'(|cfg_o), 0);
    step();
    rst_ni = 1; awvalid = 0; wvalid = 0; arvalid = 0;
    read(BASE + 'h10, d, r);
    chk("cfg0 after reset", d, 0);
    chk("cfg0 resp", r, 0);
    write(BASE + 'h28, 64'h1122334455667788, 8'h0F, 0, r);
    chk("cfg3 bresp", r, 0);
    read(BASE + 'h28, d, r);
    chk("cfg3 rdata", d, 64'h0000000055667788);
    chk("cfg3 cfg_o", cfg_o[255:192], 64'h0000000055667788);
    s0 = start_cnt;
    acc_busy = 1;
    write(BASE, 64'h3, 8'h01, 0, r);
    step(); step();
    chk("start pulse count", 64'(start_cnt - s0), 1);
    acc_done = 1;
    step();
    acc_done = 0;
    read(BASE + 'h8, d, r);
    chk("status done+busy", d, 64'h3);
    chk("irq set", irq, 1);
    acc_busy = 0;
    write(BASE + 'h8, 64'h2, 8'h02, 0, r);
    read(BASE + 'h8, d, r);
    chk("status w1c no strb0", d, 64'h2);
    write(BASE + 'h8, 64'h2, 8'h01, 0, r);
    read(BASE + 'h8, d, r);
    chk("status cleared", d, 64'h0);
    chk("irq cleared", irq, 0);
    write(BASE + 'h8, 64'h2, 8'h01, 1, r);
    read(BASE + 'h8, d, r);
    chk("done set wins", d, 64'h2);
    write(BASE + 'h8, 64'h2, 8'h01, 0, r);
    read(BASE + 'h1000, d, r);
    chk("decerr read resp", r, 2'b11);
    chk("decerr read data", d, 0);
    write(64'h4FFF_FFF8, '1, 8'hFF, 0, r);
    chk("decerr write resp", r, 2'b11);
    read(BASE + 'h800, d, r);
    chk("hole read data", d, 0);
    chk("hole read resp", r, 0);
    write(BASE + 'h78, 64'hDEADBEEFCAFEF00D, 8'hFF, 0, r);
    read(BASE + 'h78, d, r);
    chk("cfg13 rdata", d, 64'hDEADBEEFCAFEF00D);
    write(BASE + 'h80, '1, 8'hFF, 0, r);
    chk("past cfg write resp", r, 0);
    read(BASE + 'h80, d, r);
    chk("past cfg read", d, 0);
    write(BASE + 'h2D, 64'hAABBCCDD00000000, 8'hF0, 0, r);
    read(BASE + 'h28, d, r);
    chk("cfg3 low bits ignored", d, 64'hAABBCCDD55667788);
    step();
    araddr = BASE + 'h28; arvalid = 1;
    awaddr = BASE + 'h18; wdata = 64'h0123; wstrb = 8'hFF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    chk("both: awready", awready, 1);
    chk("both: arready", arready, 0);
    step();
    awvalid = 0; wvalid = 0;
    repeat (5) begin
      @(negedge clk);
      chk("hold bvalid", bvalid, 1);
      chk("hold bresp", bresp, 0);
      chk("hold arready", arready, 0);
    end
    step();
    bready = 1;
    step();
    bready = 0;
    @(negedge clk);
    chk("ar after b", arready, 1);
    step();
    arvalid = 0; rready = 1;
    @(negedge clk);
    chk("queued rvalid", rvalid, 1);
    chk("queued rdata", rdata, 64'hAABBCCDD55667788);
    step();
    rready = 0;
    step();
    awaddr = BASE + 'h20; wdata = 64'hCAFE00000000BEEF; wstrb = 8'hFF; awvalid = 1; wvalid = 0;
    repeat (4) begin
      @(negedge clk);
      chk("aw only awready", awready, 0);
      chk("aw only wready", wready, 0);
    end
    step();
    wvalid = 1;
    @(negedge clk);
    chk("aw+w awready", awready, 1);
    chk("aw+w wready", wready, 1);
    step();
    awvalid = 0; wvalid = 0; bready = 1;
    @(negedge clk);
    chk("aw+w bvalid", bvalid, 1);
    step();
    bready = 0;
    read(BASE + 'h20, d, r);
    chk("cfg2 rdata", d, 64'hCAFE00000000BEEF);
    step();
    awaddr = BASE + 'h10; wdata = 64'h5; wstrb = 8'hFF; awvalid = 1; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    step();
    rst_ni = 0;
    step();
    rst_ni = 1;
    @(negedge clk);
    chk("mid reset bvalid", bvalid, 0);
    chk("mid reset cfg_o", 64'(|cfg_o), 0);
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
